instruction_fetch: RTL and testbench

//  IF stage of the 5-stage MIPS pipeline: owns the PC and the instruction memory, and feeds
//  the IF/ID register (o_pc4, o_instruction) to instruction_decode.

---
 rtl/instruction_fetch.sv | 109 ++++++++++
 tb/tb_instruction_fetch.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// IF stage of the 5-stage MIPS pipeline: PC, instruction memory and the IF/ID register.
// The debug unit loads memory while IDLE; a fetched 32'hFFFFFFFF ends the run.
module instruction_fetch #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_jump,
  input  logic [31:0]       i_jump_addr,
  input  logic              i_stall,
  input  logic              i_halt,
  input  logic              i_imem_we,
  input  logic [ADDR_W-1:0] i_imem_addr,
  input  logic [31:0]       i_imem_data,
  output logic [31:0]       o_pc,
  output logic [31:0]       o_pc4,
  output logic [31:0]       o_instruction,
  output logic              o_running,
  output logic              o_done
);

  localparam logic [31:0] Nop  = 32'h0000_0000;
  localparam logic [31:0] Halt = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] instr_q, instr_d;
  logic        mem_we;
  logic [31:0] fetch_word;
  logic [31:0] pc_plus4;

  logic [31:0] mem [MEM_DEPTH];

  // Addresses beyond MEM_DEPTH alias onto the low word index bits.
  assign fetch_word = mem[pc_q[ADDR_W+1:2]];
  assign pc_plus4   = pc_q + 32'd4;

  logic unused_jump_lsb;
  assign unused_jump_lsb = ^i_jump_addr[1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    instr_d = instr_q;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!i_halt) begin
          mem_we = i_imem_we;
          if (i_start) state_d = StRun;
        end
      end
      StRun: begin
        if (!i_halt && !i_stall) begin
          if (i_jump) begin
            // Taken jump flushes the fetched slot; there is no delay slot.
            pc_d    = {i_jump_addr[31:2], 2'b00};
            pc4_d   = 32'd0;
            instr_d = Nop;
          end else begin
            pc4_d   = pc_plus4;
            instr_d = fetch_word;
            if (fetch_word == Halt) begin
              state_d = StDone;
            end else begin
              pc_d = pc_plus4;
            end
          end
        end
      end
      StDone: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
      pc_q    <= 32'd0;
      pc4_q   <= 32'd0;
      instr_q <= Nop;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
    end
  end

  // Memory survives reset so a program can be re-run after a reset.
  always_ff @(posedge i_clk) begin
    if (mem_we && !i_reset) begin
      mem[i_imem_addr] <= i_imem_data;
    end
  end

  assign o_pc          = pc_q;
  assign o_pc4         = pc4_q;
  assign o_instruction = instr_q;
  assign o_running     = (state_q == StRun);
  assign o_done        = (state_q == StDone);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by random stimulus,
// all checked every cycle against a behavioural model of the fetch stage.
module tb_instruction_fetch;

  localparam int Depth = 256;

  logic        clk = 1'b0;
  logic        reset, start, jump, stall, halt, we;
  logic [31:0] jaddr, wdata;
  logic [7:0]  waddr;
  logic [31:0] pc, pc4, instr;
  logic        running, done;

  int total = 0;
  int bad   = 0;

  // Behavioural model: mode 0 = idle, 1 = running, 2 = finished.
  logic [31:0] m_mem [Depth];
  logic [31:0] m_pc = 0, m_pc4 = 0, m_ins = 0;
  int          m_mode = 0;

  instruction_fetch #(.MEM_DEPTH(256), .ADDR_W(8)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .i_jump       (jump),
    .i_jump_addr  (jaddr),
    .i_stall      (stall),
    .i_halt       (halt),
    .i_imem_we    (we),
    .i_imem_addr  (waddr),
    .i_imem_data  (wdata),
    .o_pc         (pc),
    .o_pc4        (pc4),
    .o_instruction(instr),
    .o_running    (running),
    .o_done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    logic [31:0] w;
    if (reset) begin
      m_pc = 0; m_pc4 = 0; m_ins = 0; m_mode = 0;
      return;
    end
    if (m_mode == 0) begin
      if (!halt) begin
        if (we) m_mem[waddr] = wdata;
        if (start) m_mode = 1;
      end
    end else if (m_mode == 1 && !halt && !stall) begin
      if (jump) begin
        m_pc  = jaddr & 32'hFFFF_FFFC;
        m_pc4 = 0;
        m_ins = 0;
      end else begin
        w     = m_mem[(m_pc / 4) % Depth];
        m_ins = w;
        m_pc4 = m_pc + 4;
        if (w == 32'hFFFF_FFFF) m_mode = 2;
        else m_pc = m_pc + 4;
      end
    end
  endtask

  // One clock: model the edge, let the DUT take it, compare just after.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    chk("pc", pc, m_pc);
    chk("pc4", pc4, m_pc4);
    chk("instr", instr, m_ins);
    chk("running", {31'd0, running}, {31'd0, m_mode == 1});
    chk("done", {31'd0, done}, {31'd0, m_mode == 2});
  endtask

  initial begin
    reset = 1; start = 0; jump = 0; stall = 0; halt = 0; we = 0;
    jaddr = 0; wdata = 0; waddr = 0;
    cycle();
    cycle();
    chk("rst_pc", pc, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_running", {31'd0, running}, 32'd0);
    reset = 0;

    // Fill memory with non-HALT words, then place the program and marker words.
    for (int i = 0; i < Depth; i++) begin
      we = 1; waddr = 8'(i);
      wdata = $urandom();
      if (wdata == 32'hFFFF_FFFF) wdata = 32'h1234_5678;
      cycle();
    end
    begin
      logic [31:0] prog [8];
      logic [7:0]  locs [8];
      prog = '{32'h2001_0005, 32'h2002_0003, 32'h0022_1820, 32'hFFFF_FFFF,
               32'h8C04_0010, 32'h1111_2222, 32'h2005_00FF, 32'h0000_0000};
      locs = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd16, 8'd18, 8'd255, 8'd17};
      for (int i = 0; i < 7; i++) begin
        waddr = locs[i]; wdata = prog[i];
        cycle();
      end
    end
    we = 0;

    // Sequential program ending in HALT
    start = 1; cycle(); start = 0;
    chk("start_pc", pc, 32'd0);
    chk("start_run", {31'd0, running}, 32'd1);
    cycle(); chk("seq0", instr, 32'h2001_0005); chk("seq0_pc4", pc4, 32'd4);
    cycle(); chk("seq1", instr, 32'h2002_0003); chk("seq1_pc4", pc4, 32'd8);
    cycle(); chk("seq2", instr, 32'h0022_1820); chk("seq2_pc4", pc4, 32'd12);
    cycle(); chk("seq3", instr, 32'hFFFF_FFFF); chk("seq3_pc4", pc4, 32'd16);
    chk("done_pc", pc, 32'd12);
    chk("done_flag", {31'd0, done}, 32'd1);
    stall = 1; jump = 1; jaddr = 32'h80; start = 1; we = 1;
    cycle(); cycle();
    chk("done_frozen", pc, 32'd12);
    stall = 0; jump = 0; start = 0; we = 0;

    // Reset from DONE, re-run from retained memory
    reset = 1; cycle(); reset = 0;
    chk("rerst_pc", pc, 32'd0);
    chk("rerst_instr", instr, 32'd0);
    chk("rerst_done", {31'd0, done}, 32'd0);
    start = 1; cycle(); start = 0;
    cycle(); chk("rerun0", instr, 32'h2001_0005);
    cycle(); chk("rerun_pc", pc, 32'd8);

    // Jump flush at PC=8
    jump = 1; jaddr = 32'h40; cycle(); jump = 0;
    chk("jmp_nop", instr, 32'd0);
    chk("jmp_pc", pc, 32'h40);
    cycle();
    chk("jmp_fetch", instr, 32'h8C04_0010);
    chk("jmp_pc4", pc4, 32'h44);

    // Stall with a jump held: nothing moves
    stall = 1; jump = 1; jaddr = 32'h100;
    cycle(); cycle(); cycle();
    chk("stall_pc", pc, 32'h44);
    chk("stall_pc4", pc4, 32'h44);
    chk("stall_instr", instr, 32'h8C04_0010);
    stall = 0; jump = 0;
    cycle();
    chk("stall_resume_pc4", pc4, 32'h48);
    chk("stall_resume_instr", instr, m_mem[17]);

    // Halt with a memory write attempt at word 18
    halt = 1; we = 1; waddr = 8'd18; wdata = 32'hDEAD_BEEF;
    cycle(); cycle();
    chk("halt_pc", pc, 32'h48);
    halt = 0; we = 0;
    cycle();
    chk("halt_mem_kept", instr, 32'h1111_2222);

    // Jump target with low bits set, top-of-memory fetch and PC wrap
    jump = 1; jaddr = 32'hFFFF_FFFE; cycle(); jump = 0;
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_fetch", instr, 32'h2005_00FF);
    chk("wrap_pc4", pc4, 32'd0);
    chk("wrap_next_pc", pc, 32'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 3) == 0);
      halt  = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 5) == 0);
      jump  = ($urandom_range(0, 7) == 0);
      jaddr = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 1100));
      we    = ($urandom_range(0, 1) == 0);
      waddr = 8'($urandom_range(0, 255));
      wdata = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
